// File: rtl/ysyx_23060208_isram.sv
// Instruction-side AXI4-Lite read slave: word store with backdoor preload and
// fixed or LFSR-driven response latency, one outstanding read at a time.
module ysyx_23060208_isram #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 1024,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter bit                    RAND_DELAY  = 1'b1,
  parameter int                    FIXED_DELAY = 0,
  parameter int                    DELAY_BITS  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    isram_araddr,
  input  logic                     isram_arvalid,
  output logic                     isram_arready,
  output logic [DATA_WIDTH-1:0]    isram_rdata,
  output logic                     isram_rvalid,
  output logic [1:0]               isram_rresp,
  input  logic                     isram_rready,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [DATA_WIDTH-1:0]    ld_data
);

  localparam int                    IDX_W   = $clog2(DEPTH);
  localparam int                    CNT_W   = 8;
  localparam logic [DATA_WIDTH-1:0] SPAN    = DATA_WIDTH'(DEPTH * 4);
  localparam logic [IDX_W:0]        DEPTH_L = (IDX_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, DELAY, RESP} state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next, delay;
  logic [7:0]            lfsr;
  logic [DATA_WIDTH-1:0] addr, addr_sel, off;
  logic [IDX_W-1:0]      idx;
  logic                  addr_ok, load_resp, ar_hs;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign isram_arready = (state == IDLE) && !rst;
  assign isram_rvalid  = (state == RESP);
  assign ar_hs         = isram_arvalid && isram_arready;
  assign delay         = RAND_DELAY ? CNT_W'(lfsr[DELAY_BITS-1:0]) : CNT_W'(FIXED_DELAY);

  // A zero-delay read enters RESP on the handshake edge, so decode the live bus address there.
  assign addr_sel = (state == IDLE) ? isram_araddr : addr;
  assign off      = addr_sel - BASE_ADDR;
  assign addr_ok  = (addr_sel[1:0] == 2'b00) && (off < SPAN);
  assign idx      = off[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 8'h5A;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (ar_hs) begin
        addr <= isram_araddr;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_resp  = 1'b0;
    case (state)
      IDLE: begin
        if (ar_hs) begin
          if (delay == '0) begin
            state_next = RESP;
            load_resp  = 1'b1;
          end else begin
            state_next = DELAY;
            cnt_next   = delay;
          end
        end
      end
      DELAY: begin
        if (cnt == CNT_W'(1)) begin
          state_next = RESP;
          load_resp  = 1'b1;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (isram_rready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered read: a same-edge backdoor write to this word returns the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      isram_rdata <= '0;
      isram_rresp <= 2'b00;
    end else if (load_resp) begin
      isram_rdata <= addr_ok ? mem[idx] : '0;
      isram_rresp <= addr_ok ? 2'b00 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_we && ({1'b0, ld_idx} < DEPTH_L)) begin
      mem[ld_idx] <= ld_data;
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_isram.sv
// Bench for ysyx_23060208_isram: three instances (fixed 0, fixed 3, random delay)
// driven by a vector table, corner sequences and a randomized run against a model.
module tb_ysyx_23060208_isram;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr  [3];
  logic        arvalid [3];
  logic        arready [3];
  logic [31:0] rdata   [3];
  logic        rvalid  [3];
  logic [1:0]  rresp   [3];
  logic        rready  [3];
  logic        ld_we   [3];
  logic [9:0]  ld_idx  [3];
  logic [31:0] ld_data [3];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    ysyx_23060208_isram #(
      .RAND_DELAY (gi == 2),
      .FIXED_DELAY(gi == 1 ? 3 : 0)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .isram_araddr (araddr[gi]),
      .isram_arvalid(arvalid[gi]),
      .isram_arready(arready[gi]),
      .isram_rdata  (rdata[gi]),
      .isram_rvalid (rvalid[gi]),
      .isram_rresp  (rresp[gi]),
      .isram_rready (rready[gi]),
      .ld_we        (ld_we[gi]),
      .ld_idx       (ld_idx[gi]),
      .ld_data      (ld_data[gi])
    );
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] gmem [1024];
  logic [7:0]  m_lfsr;

  // Reference LFSR: feedback is the parity of the tapped bits x^8,x^6,x^5,x^4.
  always @(posedge clk) m_lfsr <= rst ? 8'h5A : {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};

  int          r_lat;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic [7:0]  r_lfsr_hs;

  typedef struct {
    int          k;
    logic [31:0] addr;
    int          hold;
    int          lat;
    logic [1:0]  resp;
    logic [31:0] data;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected response for an address, straight from the decode rule.
  task automatic model(input logic [31:0] addr, output logic [1:0] resp, output logic [31:0] data);
    logic [31:0] off;
    off = addr - 32'h8000_0000;
    if (addr % 4 == 0 && off < 32'd4096) begin
      resp = 2'b00;
      data = gmem[off / 4];
    end else begin
      resp = 2'b10;
      data = 32'h0;
    end
  endtask

  // Called on a negedge; returns on the negedge after the R handshake.
  task automatic do_read(input int k, input logic [31:0] addr, input int hold);
    int budget;
    bit stall_bad, hold_bad;
    araddr[k]  = addr;
    arvalid[k] = 1'b1;
    rready[k]  = (hold == 0);
    budget = 0;
    while (!arready[k] && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    chk($sformatf("ar_handshake_k%0d", k), 32'(arready[k]), 32'd1);
    if (!arready[k]) begin
      arvalid[k] = 1'b0;
      r_lat = -1;
      return;
    end
    r_lfsr_hs = m_lfsr;
    @(posedge clk);
    @(negedge clk);
    arvalid[k] = 1'b0;
    araddr[k]  = 32'hDEAD_BEEF;
    for (int j = 0; j < 3; j++) ld_we[j] = 1'b0;
    r_lat = 0;
    stall_bad = 1'b0;
    while (!rvalid[k] && r_lat < 50) begin
      if (arready[k]) stall_bad = 1'b1;
      @(negedge clk);
      r_lat++;
    end
    chk($sformatf("rvalid_seen_k%0d", k), 32'(rvalid[k]), 32'd1);
    if (!rvalid[k]) begin
      r_lat = -1;
      rready[k] = 1'b1;
      return;
    end
    chk($sformatf("arready_low_wait_k%0d", k), 32'(stall_bad), 32'd0);
    r_data = rdata[k];
    r_resp = rresp[k];
    hold_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rvalid[k] || rdata[k] !== r_data || rresp[k] !== r_resp || arready[k]) hold_bad = 1'b1;
    end
    if (hold > 0) chk($sformatf("hold_stable_k%0d", k), 32'(hold_bad), 32'd0);
    rready[k] = 1'b1;
    @(negedge clk);
    chk($sformatf("arready_after_r_k%0d", k), 32'(arready[k]), 32'd1);
    chk($sformatf("rvalid_after_r_k%0d", k), 32'(rvalid[k]), 32'd0);
    $display("[TB] read k=%0d addr=%h hold=%0d lat=%0d resp=%0d data=%h",
             k, addr, hold, r_lat, r_resp, r_data);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, exp_data;
    logic [1:0]  exp_resp;
    logic [3:0]  seen;
    bit          bad;

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      araddr[k] = '0; arvalid[k] = 1'b0; rready[k] = 1'b1;
      ld_we[k] = 1'b0; ld_idx[k] = '0; ld_data[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("arready_in_rst_k%0d", k), 32'(arready[k]), 32'd0);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_arready_k%0d", k), 32'(arready[k]), 32'd1);
      chk($sformatf("rst_rvalid_k%0d", k), 32'(rvalid[k]), 32'd0);
      chk($sformatf("rst_rdata_k%0d", k), rdata[k], 32'd0);
      chk($sformatf("rst_rresp_k%0d", k), 32'(rresp[k]), 32'd0);
    end

    // Preload every instance with the same image.
    @(negedge clk);
    for (int i = 0; i < 1024; i++) begin
      gmem[i] = (i == 0) ? 32'h0000_0413 : (i == 1) ? 32'h0010_0093 : 32'h1000_0000 + 32'(i);
      for (int k = 0; k < 3; k++) begin
        ld_we[k] = 1'b1; ld_idx[k] = 10'(i); ld_data[k] = gmem[i];
      end
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) ld_we[k] = 1'b0;

    vt[0] = '{0, 32'h8000_0000, 0, 0, 2'b00, 32'h0000_0413};
    vt[1] = '{1, 32'h8000_0004, 0, 3, 2'b00, 32'h0010_0093};
    vt[2] = '{0, 32'h8000_0004, 5, 0, 2'b00, 32'h0010_0093};
    vt[3] = '{1, 32'h8000_0002, 0, 3, 2'b10, 32'h0};
    vt[4] = '{1, 32'h8000_1000, 0, 3, 2'b10, 32'h0};
    vt[5] = '{0, 32'h7FFF_FFFC, 0, 0, 2'b10, 32'h0};
    vt[6] = '{0, 32'h8000_0FFC, 0, 0, 2'b00, 32'h1000_03FF};
    vt[7] = '{1, 32'h8000_0008, 5, 3, 2'b00, 32'h1000_0002};
    for (int v = 0; v < 8; v++) begin
      do_read(vt[v].k, vt[v].addr, vt[v].hold);
      if (r_lat >= 0) begin
        chk($sformatf("vec%0d_lat", v), 32'(r_lat), 32'(vt[v].lat));
        chk($sformatf("vec%0d_resp", v), 32'(r_resp), 32'(vt[v].resp));
        chk($sformatf("vec%0d_data", v), r_data, vt[v].data);
      end
    end

    // Backdoor write to the word being read on the RESP-entry edge returns old data.
    for (int k = 0; k < 3; k++) begin
      ld_we[k] = 1'b1; ld_idx[k] = 10'd5; ld_data[k] = 32'hCAFE_0005;
    end
    do_read(0, 32'h8000_0014, 0);
    chk("rbw_old_data", r_data, gmem[5]);
    gmem[5] = 32'hCAFE_0005;
    do_read(0, 32'h8000_0014, 0);
    chk("rbw_new_data", r_data, gmem[5]);

    // Randomized back-to-back reads on the LFSR-delay instance.
    seen = '0;
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(9))
        0: a = 32'h8000_0000 + ($urandom_range(1023) * 4) + 32'($urandom_range(3, 1));
        1: a = ($urandom_range(1)) ? 32'h8000_1000 + ($urandom_range(255) * 4)
                                   : 32'h7FFF_FFFC - ($urandom_range(255) * 4);
        default: a = 32'h8000_0000 + ($urandom_range(1023) * 4);
      endcase
      model(a, exp_resp, exp_data);
      do_read(2, a, ($urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : 0);
      if (r_lat >= 0) begin
        chk($sformatf("rand%0d_lat", n), 32'(r_lat), 32'(r_lfsr_hs[1:0]));
        chk($sformatf("rand%0d_resp", n), 32'(r_resp), 32'(exp_resp));
        chk($sformatf("rand%0d_data", n), r_data, exp_data);
        if (r_lat < 4) seen[r_lat] = 1'b1;
      end
    end
    chk("all_delays_seen", 32'(seen), 32'hF);

    // Reset while the fixed-delay instance is one edge away from responding.
    araddr[1] = 32'h8000_0008; arvalid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arvalid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rvalid", 32'(rvalid[1]), 32'd0);
    chk("midrst_arready_in_rst", 32'(arready[1]), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_arready_after", 32'(arready[1]), 32'd1);
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rvalid[1]) bad = 1'b1;
    end
    chk("midrst_no_response", 32'(bad), 32'd0);
    do_read(1, 32'h8000_0008, 0);
    if (r_lat >= 0) begin
      chk("midrst_fresh_lat", 32'(r_lat), 32'd3);
      chk("midrst_fresh_resp", 32'(r_resp), 32'd0);
      chk("midrst_fresh_data", r_data, gmem[2]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
